aes_ctr_ctrl: RTL

//  CTR-mode front/back end for aes_enc. Accepts plaintext blocks on a valid/ready stream, issues the running

---
 rtl/aes_ctr_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/aes_ctr_ctrl.sv
// aes_ctr_ctrl: CTR-mode wrapper around aes_enc.
// Takes plaintext blocks, sends the running counter block and key to aes_enc,
// XORs the returned keystream with the held plaintext and presents the
// ciphertext on a registered valid/ready output. One encryption in flight.
// Optional build macro AES_CTR_PARTIAL_EN: zero the unused tail bytes of a
// short last block (pt_bytes_i = 1..15); otherwise pt_bytes_i is ignored.
module aes_ctr_ctrl #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         cfg_start_i,
  input  logic [127:0] cfg_key_i,
  input  logic [127:0] cfg_iv_i,
  input  logic         pt_valid_i,
  input  logic [127:0] pt_data_i,
  input  logic         pt_last_i,
  input  logic [3:0]   pt_bytes_i,
  output logic         pt_ready_o,
  output logic         enc_data_v_o,
  output logic [127:0] enc_data_o,
  output logic [127:0] enc_key_o,
  input  logic         enc_res_v_i,
  input  logic [127:0] enc_res_i,
  output logic         ct_valid_o,
  output logic [127:0] ct_data_o,
  output logic         ct_last_o,
  input  logic         ct_ready_i,
  output logic         busy_o,
  output logic         ctr_wrap_o
);

  typedef enum logic {IDLE, RUN} state_t;

  // Ones over the incrementing counter field, zeros over the fixed upper part.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

  state_t       state, state_nxt;
  logic [127:0] key_q, ctr_q, pt_q;
  logic         last_q;
  logic         busy_q, ct_valid_q, ct_last_q, wrap_q;
  logic [127:0] ct_data_q;
  logic [127:0] ct_mask;
  logic [127:0] ctr_inc;
  logic         start_acc, pt_fire, res_fire, ct_fire, ctr_at_max;

  assign start_acc  = cfg_start_i & ~busy_q & ~ct_valid_q;
  assign pt_ready_o = (state == RUN) & ~busy_q & (~ct_valid_q | ct_ready_i);
  assign pt_fire    = pt_valid_i & pt_ready_o;
  assign res_fire   = enc_res_v_i & busy_q;
  assign ct_fire    = ct_valid_q & ct_ready_i;

  // Increment only the low counter field; the carry out of it is discarded.
  assign ctr_inc    = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
  assign ctr_at_max = ((ctr_q & CTR_MASK) == CTR_MASK);

  assign enc_data_v_o = pt_fire;
  assign enc_data_o   = ctr_q;
  assign enc_key_o    = key_q;
  assign busy_o       = busy_q;
  assign ct_valid_o   = ct_valid_q;
  assign ct_data_o    = ct_data_q;
  assign ct_last_o    = ct_last_q;
  assign ctr_wrap_o   = wrap_q;

`ifdef AES_CTR_PARTIAL_EN
  logic [3:0] bytes_q;

  // Remember how many bytes of the current block are meaningful.
  always_ff @(posedge clk) begin
    if (!nreset)      bytes_q <= 4'd0;
    else if (pt_fire) bytes_q <= pt_bytes_i;
  end

  // Keep bytes below the count on a short last block, clear the rest.
  always_comb begin
    ct_mask = {128{1'b1}};
    if (last_q && (bytes_q != 4'd0)) begin
      for (int k = 0; k < 16; k++) begin
        if (4'(k) >= bytes_q) ct_mask[8*k +: 8] = 8'h00;
      end
    end
  end
`else
  logic unused_bytes;
  assign unused_bytes = ^pt_bytes_i;
  assign ct_mask      = {128{1'b1}};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // A start enters (or restarts) RUN; the last ciphertext handshake ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_acc) state_nxt = RUN;
      RUN: begin
        if (start_acc)                 state_nxt = RUN;
        else if (ct_fire && ct_last_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Key, counter and sticky wrap flag: loaded on start, counter steps per issued block.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      key_q  <= '0;
      ctr_q  <= '0;
      wrap_q <= 1'b0;
    end else if (start_acc) begin
      key_q  <= cfg_key_i;
      ctr_q  <= cfg_iv_i;
      wrap_q <= 1'b0;
    end else if (pt_fire) begin
      ctr_q <= ctr_inc;
      if (ctr_at_max) wrap_q <= 1'b1;
    end
  end

  // Hold the plaintext while aes_enc works; busy covers issue to result.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pt_q   <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (pt_fire) begin
        pt_q   <= pt_data_i;
        last_q <= pt_last_i;
      end
      if (pt_fire)       busy_q <= 1'b1;
      else if (res_fire) busy_q <= 1'b0;
    end
  end

  // Ciphertext output register: filled by a result, emptied by a handshake.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      ct_last_q  <= 1'b0;
    end else if (res_fire) begin
      ct_valid_q <= 1'b1;
      ct_data_q  <= (enc_res_i ^ pt_q) & ct_mask;
      ct_last_q  <= last_q;
    end else if (ct_fire) begin
      ct_valid_q <= 1'b0;
    end
  end

endmodule
